sevenseg_scan_driver: RTL
=========================

// Module: sevenseg_scan_driver
// PURPOSE
//  Time-multiplexed N-digit hex seven-segment driver; next generation of the single-digit decoder.
//  - Scans NUM_DIGITS digits over one shared segment bus with per-digit anode enables.
//  - Adds per-digit blanking, decimal points, leading-zero suppression, and anti-ghost dead time.
//  - Adds frame-synchronous (tear-free) value update.
//  - Sits between the alarm/distance datapath (BCD or hex nibbles) and the board LED pins.
// PARAMETERS
//  NUM_DIGITS      4      digits scanned, legal 1..8
//  SCAN_DIV        50000  clock cycles per digit slot, >= 2
//  BLANK_CYC       500    dead-time cycles at the start of each slot (all anodes off), < SCAN_DIV
//  ACTIVE_LOW_SEG  1      1: segment/DP pins are 0 = lit; 0: 1 = lit
//  ACTIVE_LOW_AN   1      1: anode pin 0 = digit on; 0: 1 = digit on
// PORTS
//  i_Clk      in   1             system clock
//  i_Rst_n    in   1             synchronous reset, active-low
//  i_Value    in   4*NUM_DIGITS  nibble k = digit k (digit 0 = least significant, rightmost)
//  i_Dp       in   NUM_DIGITS    decimal point per digit, 1 = lit
//  i_Blank    in   NUM_DIGITS    force digit dark (segments and DP), 1 = blank
//  i_Lz_En    in   1             1 = suppress leading zeros
//  i_Load     in   1             strobe: capture i_Value/i_Dp/i_Blank into pending register
//  o_Seg      out  [0:6]         segments a..g, bit 0 = a, polarity per ACTIVE_LOW_SEG
//  o_Dp       out  1             decimal-point pin, polarity per ACTIVE_LOW_SEG
//  o_An       out  NUM_DIGITS    anode enables, at most one active, polarity per ACTIVE_LOW_AN
//  o_Frame    out  1             one-cycle pulse when digit index wraps to 0
// BEHAVIOUR
//  Reset (i_Rst_n = 0 at posedge):
//  - Prescaler p = 0, digit index k = 0; pending and display registers = 0 (all zeros, no DP, no blank).
//  - o_An all inactive, o_Seg all dark, o_Dp dark, o_Frame = 0.
//  - A mid-scan reset takes effect on that edge; no partial slot completes.
//  Scan:
//  - p counts 0..SCAN_DIV-1 and wraps. On the p = SCAN_DIV-1 edge, k advances; NUM_DIGITS-1 wraps to 0.
//  - On that wrap edge, o_Frame = 1 for one cycle, and the display register loads from the pending register.
//  Load:
//  - i_Load high at a posedge writes the pending register.
//  - If i_Load coincides with the wrap edge, the display register takes the new inputs directly (load wins).
//  - The display never changes mid-frame.
//  Outputs:
//  - Registered, 1-cycle latency: the outputs after edge t reflect p, k, and the display register before edge t.
//  - o_An(k) active iff p >= BLANK_CYC. Other anodes are inactive. o_An is all inactive while p < BLANK_CYC.
//  - Decode, active-low, pre-polarity, nibble -> a..g:
//    0:0000001 1:1001111 2:0010010 3:0000110 4:1001100 5:0100100 6:0100000 7:0001101
//    8:0000000 9:0000100 A:0001000 b:1100000 C:0110001 d:1000010 E:0110000 F:0111000
//  - ACTIVE_LOW_SEG = 0 inverts o_Seg and o_Dp.
//  Dark digit (o_Seg all off, o_Dp off, anode timing unchanged) when any of:
//  - (a) i_Blank bit k set.
//  - (b) i_Lz_En = 1, k > 0, and display nibbles k..NUM_DIGITS-1 are all zero.
//  - Digit 0 is never zero-suppressed. A DP on a suppressed digit is also dark.
//  - i_Blank takes precedence over DP.
//  NUM_DIGITS = 1:
//  - k stays 0. o_Frame pulses every SCAN_DIV cycles.
// TESTING (NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, both polarities low)
//  1 Reset held 3 cycles, released -> o_An=1111, o_Seg=1111111, o_Dp=1.
//    First o_Frame occurs 16 cycles after release.
//  2 i_Value=16'h1A2F, i_Load pulse, i_Lz_En=0 -> from next frame, slot k shows the following.
//    k=0: o_An=1110 (active for 3 of 4 cycles), o_Seg=0111000 (F).
//    k=1: o_An=1101, o_Seg=0010010 (2).
//    k=2: o_Seg=0001000 (A). k=3: o_Seg=1001111 (1).
//  3 i_Value=16'h0050, i_Lz_En=1 -> digits 3,2 dark, digit 1 = 0100100, digit 0 = 0000001.
//    i_Value=16'h0000 -> only digit 0 lit, o_Seg = 0000001.
//  4 i_Load with 16'h8888 mid-frame -> remaining slots of the current frame keep the old value.
//    i_Load on the wrap edge -> new value appears in digit 0 of the new frame.
//  5 i_Dp=4'b0100, i_Blank=4'b0100 -> digit 2 dark with o_Dp=1.
//    i_Blank=0 -> digit 2 o_Dp=0; other digits o_Dp=1.
//  6 Reset asserted during slot k=2, p=2 -> next cycle outputs dark, index 0.
//    Check ACTIVE_LOW_SEG=0: the case 2 digit 0 pattern reads 1000111.

Source files
------------

// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver
// Time-multiplexed N-digit hex seven-segment driver. One shared segment bus
// is scanned across NUM_DIGITS anodes. Each slot opens with a dead time so
// that the previous digit's pattern cannot ghost onto the next anode.
// Values are staged in a pending register and move to the display register
// only at the frame wrap, so a frame is never torn between old and new data.
module sevenseg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYC      = 500,
    parameter int ACTIVE_LOW_SEG = 1,
    parameter int ACTIVE_LOW_AN  = 1
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst_n,
    input  logic [4*NUM_DIGITS-1:0]   i_Value,
    input  logic [NUM_DIGITS-1:0]     i_Dp,
    input  logic [NUM_DIGITS-1:0]     i_Blank,
    input  logic                      i_Lz_En,
    input  logic                      i_Load,
    output logic [0:6]                o_Seg,
    output logic                      o_Dp,
    output logic [NUM_DIGITS-1:0]     o_An,
    output logic                      o_Frame
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int KW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYC);
    localparam logic [KW-1:0] K_LAST  = KW'(NUM_DIGITS - 1);

    // Pin-level "dark" levels for the selected polarities
    localparam logic [0:6]            SEG_DARK = (ACTIVE_LOW_SEG != 0) ? 7'b1111111 : 7'b0000000;
    localparam logic                  DP_DARK  = (ACTIVE_LOW_SEG != 0) ? 1'b1 : 1'b0;
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = (ACTIVE_LOW_AN != 0) ? {NUM_DIGITS{1'b1}}
                                                                       : {NUM_DIGITS{1'b0}};

    // Hex nibble to active-low a..g pattern (index 0 = segment a)
    function automatic logic [0:6] hex_to_seg(input logic [3:0] nib);
        logic [0:6] pat;
        case (nib)
            4'h0:    pat = 7'b0000001;
            4'h1:    pat = 7'b1001111;
            4'h2:    pat = 7'b0010010;
            4'h3:    pat = 7'b0000110;
            4'h4:    pat = 7'b1001100;
            4'h5:    pat = 7'b0100100;
            4'h6:    pat = 7'b0100000;
            4'h7:    pat = 7'b0001101;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0000100;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b1100000;
            4'hC:    pat = 7'b0110001;
            4'hD:    pat = 7'b1000010;
            4'hE:    pat = 7'b0110000;
            4'hF:    pat = 7'b0111000;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    // Scan position
    logic [PW-1:0]           p_r;
    logic [KW-1:0]           k_r;

    // Staged and displayed values
    logic [4*NUM_DIGITS-1:0] pend_value_r;
    logic [NUM_DIGITS-1:0]   pend_dp_r;
    logic [NUM_DIGITS-1:0]   pend_blank_r;
    logic [4*NUM_DIGITS-1:0] disp_value_r;
    logic [NUM_DIGITS-1:0]   disp_dp_r;
    logic [NUM_DIGITS-1:0]   disp_blank_r;

    // Registered pins
    logic [0:6]              seg_r;
    logic                    dp_r;
    logic [NUM_DIGITS-1:0]   an_r;
    logic                    frame_r;

    // Combinational helpers
    logic                    slot_end_s;
    logic                    wrap_s;
    logic [NUM_DIGITS-1:0]   lz_mask_s;
    logic                    zero_above_s;
    logic [3:0]              cur_nib_s;
    logic                    cur_dp_s;
    logic                    cur_blank_s;
    logic                    cur_lz_s;
    logic [NUM_DIGITS-1:0]   an_onehot_s;
    logic                    dark_s;
    logic [0:6]              seg_pre_s;
    logic                    dp_pre_s;
    logic [NUM_DIGITS-1:0]   an_pre_s;
    logic [0:6]              seg_next_s;
    logic                    dp_next_s;
    logic [NUM_DIGITS-1:0]   an_next_s;

    assign slot_end_s = (p_r == P_LAST);
    assign wrap_s     = slot_end_s && (k_r == K_LAST);

    // Prescaler and digit index; the index only moves at the end of a slot
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            p_r <= {PW{1'b0}};
            k_r <= {KW{1'b0}};
        end else if (slot_end_s) begin
            p_r <= {PW{1'b0}};
            if (k_r == K_LAST) begin
                k_r <= {KW{1'b0}};
            end else begin
                k_r <= k_r + KW'(1);
            end
        end else begin
            p_r <= p_r + PW'(1);
        end
    end

    // Pending capture on load; display refresh only at the frame wrap,
    // where a coincident load bypasses the pending stage
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            pend_value_r <= {(4*NUM_DIGITS){1'b0}};
            pend_dp_r    <= {NUM_DIGITS{1'b0}};
            pend_blank_r <= {NUM_DIGITS{1'b0}};
            disp_value_r <= {(4*NUM_DIGITS){1'b0}};
            disp_dp_r    <= {NUM_DIGITS{1'b0}};
            disp_blank_r <= {NUM_DIGITS{1'b0}};
        end else begin
            if (i_Load) begin
                pend_value_r <= i_Value;
                pend_dp_r    <= i_Dp;
                pend_blank_r <= i_Blank;
            end
            if (wrap_s) begin
                if (i_Load) begin
                    disp_value_r <= i_Value;
                    disp_dp_r    <= i_Dp;
                    disp_blank_r <= i_Blank;
                end else begin
                    disp_value_r <= pend_value_r;
                    disp_dp_r    <= pend_dp_r;
                    disp_blank_r <= pend_blank_r;
                end
            end
        end
    end

    // Leading-zero mask: digit j is suppressible when it and every digit above it are zero
    always_comb begin
        lz_mask_s    = {NUM_DIGITS{1'b0}};
        zero_above_s = 1'b1;
        for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
            zero_above_s = zero_above_s && (disp_value_r[4*j +: 4] == 4'h0);
            lz_mask_s[j] = zero_above_s && (j > 0);
        end
    end

    // Select the attributes of the digit currently being scanned
    always_comb begin
        cur_nib_s   = 4'h0;
        cur_dp_s    = 1'b0;
        cur_blank_s = 1'b0;
        cur_lz_s    = 1'b0;
        an_onehot_s = {NUM_DIGITS{1'b0}};
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (k_r == KW'(j)) begin
                cur_nib_s      = disp_value_r[4*j +: 4];
                cur_dp_s       = disp_dp_r[j];
                cur_blank_s    = disp_blank_r[j];
                cur_lz_s       = lz_mask_s[j];
                an_onehot_s[j] = 1'b1;
            end else begin
                an_onehot_s[j] = 1'b0;
            end
        end
    end

    // Build the active-low/active-high pre-polarity patterns, then apply pin polarity
    always_comb begin
        dark_s = cur_blank_s || (i_Lz_En && cur_lz_s);
        if (dark_s) begin
            seg_pre_s = 7'b1111111;
            dp_pre_s  = 1'b1;
        end else begin
            seg_pre_s = hex_to_seg(cur_nib_s);
            dp_pre_s  = ~cur_dp_s;
        end
        if (p_r >= P_BLANK) begin
            an_pre_s = an_onehot_s;
        end else begin
            an_pre_s = {NUM_DIGITS{1'b0}};
        end
        if (ACTIVE_LOW_SEG != 0) begin
            seg_next_s = seg_pre_s;
            dp_next_s  = dp_pre_s;
        end else begin
            seg_next_s = ~seg_pre_s;
            dp_next_s  = ~dp_pre_s;
        end
        if (ACTIVE_LOW_AN != 0) begin
            an_next_s = ~an_pre_s;
        end else begin
            an_next_s = an_pre_s;
        end
    end

    // Output registers: one cycle behind the scan position and display data
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            seg_r   <= SEG_DARK;
            dp_r    <= DP_DARK;
            an_r    <= AN_OFF;
            frame_r <= 1'b0;
        end else begin
            seg_r   <= seg_next_s;
            dp_r    <= dp_next_s;
            an_r    <= an_next_s;
            frame_r <= wrap_s;
        end
    end

    assign o_Seg   = seg_r;
    assign o_Dp    = dp_r;
    assign o_An    = an_r;
    assign o_Frame = frame_r;

endmodule
